// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 8-bit accumulator CPU: opcodes, controller phases, widths.
package cpu_pkg;

  localparam int OPCODE_WIDTH = 3;
  localparam int PHASE_WIDTH  = 3;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-phase sequencer: every instruction takes exactly 8 clocks, no stalls.
// Outputs are a combinational decode of phase, halted flag, opcode, zero and rst.
module cpu_controller #(
  parameter int OPCODE_WIDTH = cpu_pkg::OPCODE_WIDTH,
  parameter int PHASE_WIDTH  = cpu_pkg::PHASE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  output logic                    sel,
  output logic                    rd,
  output logic                    ld_ir,
  output logic                    inc_pc,
  output logic                    halt,
  output logic                    ld_pc,
  output logic                    data_e,
  output logic                    ld_ac,
  output logic                    wr,
  output logic [PHASE_WIDTH-1:0]  phase
);
  import cpu_pkg::*;

  phase_t phase_q;
  logic   halted;
  logic   aluop;

  assign aluop = is_aluop(opcode);
  assign phase = phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= INST_ADDR;
      halted  <= 1'b0;
    end else if (!halted) begin
      // HLT freezes the counter at OP_ADDR rather than advancing past it
      if (phase_q == OP_ADDR && opcode == HLT) begin
        halted <= 1'b1;
      end else begin
        phase_q <= phase_t'(phase_q + 3'd1);
      end
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (rst) begin
      // everything stays low while reset is held
    end else if (halted) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        IDLE: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == HLT);
        end
        OP_FETCH: rd = aluop;
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
          wr     = (opcode == STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized scoreboard bench for cpu_controller against an instruction-level reference model.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;

  typedef struct packed {
    logic [2:0] ph;
    logic [8:0] strobes; // {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;
  bit   done   = 0;

  // reference model state: position within the instruction and halted flag
  int   m_step   = 0;
  bit   m_halted = 0;
  int   m_shown  = 0;

  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
    .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model_strobes(input int step, input bit hlt_d, input logic r,
                                               input logic [2:0] op, input logic z);
    bit fetch, execute, alu, e_sel, e_rd, e_ir, e_inc, e_halt, e_ldpc, e_de, e_ac, e_wr;
    fetch   = (step < 4);
    execute = (step >= 6);
    alu     = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    if (r) return 9'b0;
    if (hlt_d) return 9'b0_0001_0000;
    e_sel  = fetch;
    e_rd   = (fetch && step != 0) || (alu && step >= 5);
    e_ir   = (step == 2);
    e_inc  = (step == 4) || (step == 6 && op == 3'd1 && z);
    e_halt = (step == 4) && (op == 3'd0);
    e_ldpc = execute && (op == 3'd7);
    e_de   = execute && (op == 3'd6);
    e_ac   = alu && step == 7;
    e_wr   = (op == 3'd6) && step == 7;
    return {e_sel, e_rd, e_ir, e_inc, e_halt, e_ldpc, e_de, e_ac, e_wr};
  endfunction

  // Drive one clock of inputs, record expectation, then advance the model past the next edge.
  task automatic cyc(input logic r, input logic [2:0] op, input logic z);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; opcode = op; zero = z;
    e.ph      = 3'(m_shown);
    e.strobes = model_strobes(m_step, m_halted, r, op, z);
    exp_q.push_back(e);
    if (r) begin
      m_step = 0; m_halted = 0;
    end else if (!m_halted) begin
      if (m_step == 4 && op == 3'd0) m_halted = 1;
      else m_step = (m_step + 1) % 8;
    end
    m_shown = m_step;
  endtask

  // One instruction: opcode is junk until phase 3; zero is random unless forced at a phase.
  task automatic instr(input logic [2:0] op, input int zmode);
    logic z;
    for (int k = 0; k < 8; k++) begin
      case (zmode)
        0: z = 1'b0;
        1: z = 1'b1;
        2: z = (k == 5);
        default: z = 1'($urandom_range(0, 1));
      endcase
      cyc(1'b0, (k < 3) ? 3'($urandom_range(0, 7)) : op, z);
    end
  endtask

  initial begin
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
        cyc_n++;
        checks++;
        if (got !== e.strobes || phase !== e.ph) begin
          errors++;
          $display("FAIL outputs cyc=%0d: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                   cyc_n, phase, got, e.ph, e.strobes);
        end
        checks++;
        if ((wr && !data_e) || (wr && sel)) begin
          errors++;
          $display("FAIL wr_invariant cyc=%0d: got wr=%b data_e=%b sel=%b, expected wr only with data_e and without sel",
                   cyc_n, wr, data_e, sel);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected stimulus to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = 3'd0; zero = 1'b0;
    cyc(1'b1, 3'd0, 1'b0);
    cyc(1'b1, 3'd3, 1'b1);
    instr(3'd2, 3);            // ADD
    instr(3'd6, 3);            // STO
    instr(3'd1, 1);            // SKZ, zero=1
    instr(3'd1, 0);            // SKZ, zero=0
    instr(3'd1, 2);            // SKZ, zero only in phase 5
    instr(3'd7, 3);            // JMP
    instr(3'd5, 3);            // LDA
    for (int k = 0; k < 5; k++) cyc(1'b0, (k < 3) ? 3'd5 : 3'd0, 1'b0);
    for (int k = 0; k < 20; k++) cyc(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    cyc(1'b1, 3'd0, 1'b0);
    cyc(1'b1, 3'd0, 1'b0);
    // reset in the middle of a store
    for (int k = 0; k < 6; k++) cyc(1'b0, 3'd6, 1'b0);
    cyc(1'b1, 3'd6, 1'b0);
    instr(3'd4, 3);
    instr(3'd3, 3);
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == 3'd0 && $urandom_range(0, 1) == 0) op = 3'd2;
      instr(op, 3);
      if ($urandom_range(0, 9) == 0) cyc(1'b1, op, 1'b0);
      if (m_halted) begin
        for (int k = 0; k < 3; k++) cyc(1'b0, 3'($urandom_range(0, 7)), 1'b0);
        cyc(1'b1, 3'd0, 1'b0);
      end
    end
    for (int k = 0; k < 8; k++) cyc(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
